// File: rtl/coeff_fetch_ctrl.sv
// Coefficient ROM fetch sequencer: credit-limited burst issue, latency-matched capture, pair FIFO.
// Optional stall_cycles output enabled by defining COEFF_FETCH_STALL_CNT_EN.
module coeff_fetch_ctrl #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned ROM_LATENCY = 3,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   row_count,
   output logic [ADDR_WIDTH-1:0] rom_addr_1,
   output logic [ADDR_WIDTH-1:0] rom_addr_2,
   input  logic [DATA_WIDTH-1:0] rom_data_1,
   input  logic [DATA_WIDTH-1:0] rom_data_2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data_1,
   output logic [DATA_WIDTH-1:0] out_data_2,
   output logic                  out_second_valid,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
`ifdef COEFF_FETCH_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);

   localparam int unsigned ROW_W = ADDR_WIDTH + 1;
   localparam int unsigned SUM_W = ROW_W + 1;
   // Stage 0 is the address register itself; the token exits when ROM data is valid.
   localparam int unsigned TOK_N = ROM_LATENCY + 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OUT_W = $clog2(FIFO_DEPTH + TOK_N + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ROW_W-1:0]      count_q;
   logic [ROW_W-1:0]      next_row_q;
   logic [ADDR_WIDTH-1:0] rom_addr_1_q, rom_addr_2_q;
   logic                  busy_q, done_q;
   logic [TOK_N-1:0]      tok_vld_q, tok_sv_q, tok_last_q;

   logic [DATA_WIDTH-1:0] mem_d1_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d2_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_sv_q, mem_last_q;
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      fifo_cnt_q;

   logic [OUT_W-1:0]      in_flight;
   logic                  credit_ok;
   logic                  issue_sv, issue_last;
   logic                  push, pop, head_last;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < TOK_N; i++) begin
         in_flight = in_flight + OUT_W'(tok_vld_q[i]);
      end
   end

   // Outstanding pairs (in the ROM pipe or buffered) never exceed the FIFO capacity.
   assign credit_ok  = (in_flight + OUT_W'(fifo_cnt_q)) < OUT_W'(FIFO_DEPTH);
   assign issue_sv   = ({1'b0, next_row_q} + SUM_W'(1)) < {1'b0, count_q};
   assign issue_last = ({1'b0, next_row_q} + SUM_W'(2)) >= {1'b0, count_q};

   assign push      = tok_vld_q[TOK_N-1];
   assign out_valid = (fifo_cnt_q != '0);
   assign pop       = out_valid && out_ready;
   assign head_last = mem_last_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         base_q       <= '0;
         count_q      <= '0;
         next_row_q   <= '0;
         rom_addr_1_q <= '0;
         rom_addr_2_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         tok_vld_q    <= '0;
         tok_sv_q     <= '0;
         tok_last_q   <= '0;
      end else begin
         done_q     <= 1'b0;
         tok_vld_q  <= {tok_vld_q[TOK_N-2:0], 1'b0};
         tok_sv_q   <= {tok_sv_q[TOK_N-2:0], 1'b0};
         tok_last_q <= {tok_last_q[TOK_N-2:0], 1'b0};
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (row_count != '0) begin
                     // The first pair issues on the accepting edge.
                     base_q        <= base_addr;
                     count_q       <= row_count;
                     busy_q        <= 1'b1;
                     rom_addr_1_q  <= base_addr;
                     rom_addr_2_q  <= base_addr + ADDR_WIDTH'(1);
                     tok_vld_q[0]  <= 1'b1;
                     tok_sv_q[0]   <= row_count > ROW_W'(1);
                     tok_last_q[0] <= row_count <= ROW_W'(2);
                     next_row_q    <= ROW_W'(2);
                     state_q       <= (row_count <= ROW_W'(2)) ? StDrain : StIssue;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            StIssue: begin
               if (credit_ok) begin
                  rom_addr_1_q  <= base_q + next_row_q[ADDR_WIDTH-1:0];
                  rom_addr_2_q  <= base_q + next_row_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                  tok_vld_q[0]  <= 1'b1;
                  tok_sv_q[0]   <= issue_sv;
                  tok_last_q[0] <= issue_last;
                  next_row_q    <= next_row_q + ROW_W'(2);
                  if (issue_last) begin
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (pop && head_last) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_d1_q[wr_ptr_q] <= rom_data_1;
         mem_d2_q[wr_ptr_q] <= rom_data_2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         mem_sv_q   <= '0;
         mem_last_q <= '0;
      end else begin
         if (push) begin
            mem_sv_q[wr_ptr_q]   <= tok_sv_q[TOK_N-1];
            mem_last_q[wr_ptr_q] <= tok_last_q[TOK_N-1];
            wr_ptr_q             <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
         end else if (pop && !push) begin
            fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
         end
      end
   end

`ifdef COEFF_FETCH_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (state_q == StIdle && start && row_count != '0) begin
         stall_q <= '0;
      end else if (state_q == StIssue && !credit_ok && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

   assign rom_addr_1       = rom_addr_1_q;
   assign rom_addr_2       = rom_addr_2_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign out_data_1       = out_valid ? mem_d1_q[rd_ptr_q] : '0;
   assign out_data_2       = out_valid ? mem_d2_q[rd_ptr_q] : '0;
   assign out_second_valid = out_valid & mem_sv_q[rd_ptr_q];
   assign out_last         = out_valid & head_last;

endmodule

// File: tb/tb_coeff_fetch_ctrl.sv
// Self-checking bench for coeff_fetch_ctrl: directed table, corner sequences, random bursts.
module tb_coeff_fetch_ctrl;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   row_count = '0;
   logic [AW-1:0] rom_addr_1, rom_addr_2;
   logic [DW-1:0] rom_data_1, rom_data_2;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data_1, out_data_2;
   logic          out_second_valid, out_last, busy, done;

   coeff_fetch_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ROM_LATENCY(3),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .base_addr       (base_addr),
      .row_count       (row_count),
      .rom_addr_1      (rom_addr_1),
      .rom_addr_2      (rom_addr_2),
      .rom_data_1      (rom_data_1),
      .rom_data_2      (rom_data_2),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data_1      (out_data_1),
      .out_data_2      (out_data_2),
      .out_second_valid(out_second_valid),
      .out_last        (out_last),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   // ROM: one shared table, three registered stages per port.
   logic [DW-1:0] rom [16];
   logic [DW-1:0] p1 [3];
   logic [DW-1:0] p2 [3];
   initial begin
      rom[0] = 32'h5F5F5F5F; rom[1] = 32'h1A1A1A1A; rom[2] = 32'h2E2E2E2E;
      rom[3] = 32'hA5A5A5A5; rom[4] = 32'h123478A2; rom[5] = 32'h9C7B6A88;
      rom[6] = 32'hAFAFB4C5;
      for (int i = 7; i < 16; i++) rom[i] = 32'hC0FFEE00 + i;
      for (int i = 0; i < 3; i++) begin p1[i] = '0; p2[i] = '0; end
   end
   always @(posedge clk) begin
      p1[0] <= rom[rom_addr_1]; p1[1] <= p1[0]; p1[2] <= p1[1];
      p2[0] <= rom[rom_addr_2]; p2[1] <= p2[0]; p2[2] <= p2[1];
   end
   assign rom_data_1 = p1[2];
   assign rom_data_2 = p2[2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Ready driver: fixed level or a coin flip every cycle.
   logic rand_ready = 1'b0;
   logic ready_fixed = 1'b1;
   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
   end

   typedef struct {
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic          sv;
      logic          last;
   } beat_t;
   beat_t exp_q[$];

   int            beats, exp_pairs, start_cyc, first_valid_cyc, last_cyc;
   logic [DW-1:0] first_d1, first_d2;
   logic          last_sv_seen;
   logic          hold_prev = 1'b0;
   logic [DW-1:0] held_d1;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev && out_valid) chk("hold_data", out_data_1, held_d1);
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_d1", out_data_1, e.d1);
               if (e.sv) chk("beat_d2", out_data_2, e.d2);
               chk("beat_sv", out_second_valid, e.sv);
               chk("beat_last", out_last, e.last);
            end
            if (beats == 0) begin first_d1 = out_data_1; first_d2 = out_data_2; end
            beats++;
            if (out_last) begin last_cyc = cyc; last_sv_seen = out_second_valid; end
         end
         hold_prev = out_valid && !out_ready;
         held_d1   = out_data_1;
      end
   end

   // Model: pairs = ceil(count/2), rows wrap modulo 16.
   task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] c);
      int n = int'(c);
      exp_pairs = (n + 1) / 2;
      for (int p = 0; p < exp_pairs; p++) begin
         beat_t e;
         e.d1   = rom[(int'(b) + 2 * p) % 16];
         e.d2   = rom[(int'(b) + 2 * p + 1) % 16];
         e.sv   = (2 * p + 1) < n;
         e.last = (p == exp_pairs - 1);
         exp_q.push_back(e);
      end
      beats = 0;
      first_valid_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; row_count = c;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      start_cyc = cyc;
      if (n != 0) begin
         chk("first_addr_1", rom_addr_1, b);
         chk("first_addr_2", rom_addr_2, 4'(b + 4'd1));
         chk("busy_after_start", busy, 1);
      end else begin
         chk("zero_done", done, 1);
         chk("zero_busy", busy, 0);
         repeat (8) begin
            @(negedge clk);
            if (out_valid || done || busy) break;
         end
         chk("zero_quiet", {out_valid, done, busy}, 3'b000);
      end
   endtask

   task automatic finish_burst();
      int n = 0;
      while (!done && n < 600) begin @(negedge clk); n++; end
      if (!done) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("done_after_last", cyc, last_cyc + 1);
         chk("busy_at_done", busy, 0);
         chk("beat_count", beats, exp_pairs);
         chk("queue_empty", exp_q.size(), 0);
         chk("first_valid_latency", first_valid_cyc - start_cyc, 4);
         @(negedge clk);
         chk("done_one_cycle", done, 0);
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   cnt;
      int            pairs;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic          last_sv;
   } vec_t;
   vec_t vecs[4];

   initial begin
      vecs[0] = '{base: 4'd0,  cnt: 5'd4, pairs: 2, d1: 32'h5F5F5F5F, d2: 32'h1A1A1A1A, last_sv: 1};
      vecs[1] = '{base: 4'd4,  cnt: 5'd3, pairs: 2, d1: 32'h123478A2, d2: 32'h9C7B6A88, last_sv: 0};
      vecs[2] = '{base: 4'd15, cnt: 5'd2, pairs: 1, d1: 32'hC0FFEE0F, d2: 32'h5F5F5F5F, last_sv: 1};
      vecs[3] = '{base: 4'd6,  cnt: 5'd1, pairs: 1, d1: 32'hAFAFB4C5, d2: 32'h0,        last_sv: 0};

      repeat (3) @(negedge clk);
      chk("rst_addr_1", rom_addr_1, 0);
      chk("rst_addr_2", rom_addr_2, 0);
      chk("rst_outs", {out_valid, out_last, out_second_valid, busy, done}, 0);
      chk("rst_data", {out_data_1, out_data_2}, 0);
      rst_n = 1'b1;

      // Directed table, ready held high.
      ready_fixed = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start_burst(vecs[i].base, vecs[i].cnt);
         finish_burst();
         chk("tbl_pairs", beats, vecs[i].pairs);
         chk("tbl_first_d1", first_d1, vecs[i].d1);
         if (vecs[i].pairs > 1 || vecs[i].last_sv) chk("tbl_first_d2", first_d2, vecs[i].d2);
         chk("tbl_last_sv", last_sv_seen, vecs[i].last_sv);
      end

      // Zero-length command.
      start_burst(4'd3, 5'd0);

      // Backpressure: only FD pairs may be issued before addresses freeze.
      ready_fixed = 1'b0;
      @(negedge clk);
      start_burst(4'd0, 5'd16);
      repeat (20) @(negedge clk);
      chk("freeze_addr_1", rom_addr_1, 4'd6);
      chk("freeze_addr_2", rom_addr_2, 4'd7);
      chk("freeze_valid", out_valid, 1);
      @(posedge clk); #1; start = 1'b1; base_addr = 4'd9; row_count = 5'd2;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_start_ignored", rom_addr_1, 4'd6);
      chk("freeze_busy", busy, 1);
      ready_fixed = 1'b1;
      finish_burst();

      // Reset with two beats buffered discards everything.
      ready_fixed = 1'b0;
      @(negedge clk);
      start_burst(4'd0, 5'd16);
      repeat (5) @(negedge clk);
      chk("pre_reset_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_valid_now", out_valid, 0);
      chk("reset_busy_now", busy, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ready_fixed = 1'b1;
      begin
         logic seen = 1'b0;
         repeat (8) begin @(negedge clk); seen = seen | out_valid | busy; end
         chk("post_reset_quiet", seen, 0);
      end
      start_burst(4'd0, 5'd2);
      finish_burst();
      chk("post_reset_d1", first_d1, 32'h5F5F5F5F);
      chk("post_reset_d2", first_d2, 32'h1A1A1A1A);

      // Random bursts under random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         logic [AW-1:0] b;
         logic [AW:0]   c;
         b = AW'($urandom_range(0, 15));
         c = (AW + 1)'($urandom_range(0, 16));
         start_burst(b, c);
         if (c != 0) finish_burst();
      end
      rand_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/coeff_fetch_ctrl.md
Name: coeff_fetch_ctrl

Overview:
- Upstream sequencer for the dual-port coefficient ROM (two 32-bit read ports, fixed 3-cycle address-to-data latency, no stall input).
- On a start command it issues a burst of row addresses: even rows on port 1, odd rows on port 2.
- It tracks in-flight reads with a valid-token pipeline and captures ROM data into a small FIFO.
- It presents row pairs to the downstream MAC array over a valid/ready interface. Issue is credit-limited, so downstream backpressure never loses ROM data.

Parameters:
- DATA_WIDTH, 32, ROM word width (one coefficient row).
- ADDR_WIDTH, 4, ROM address width.
- ROM_LATENCY, 3, cycles from address presented to data valid on ROM outputs.
- FIFO_DEPTH, 8, output FIFO entries (row pairs). Must be ≥ ROM_LATENCY+2 for one pair/cycle sustained.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command pulse; ignored while busy=1
- base_addr  in  ADDR_WIDTH  first row address, sampled with start
- row_count  in  ADDR_WIDTH+1  rows to fetch (0..2^ADDR_WIDTH), sampled with start
- rom_addr_1  out  ADDR_WIDTH  ROM port 1 address
- rom_addr_2  out  ADDR_WIDTH  ROM port 2 address
- rom_data_1  in  DATA_WIDTH  ROM port 1 data
- rom_data_2  in  DATA_WIDTH  ROM port 2 data
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data_1  out  DATA_WIDTH  even row of pair
- out_data_2  out  DATA_WIDTH  odd row of pair
- out_second_valid  out  1  out_data_2 carries a real row
- out_last  out  1  final pair of burst
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst_n=0, async): state IDLE, counters/tokens/FIFO cleared; rom_addr_*=0, out_valid=0, out_*=0, busy=0, done=0. Reset mid-burst discards all in-flight and buffered data. No output after deassertion until a new start.
- FSM IDLE→ISSUE→DRAIN→IDLE.
- IDLE: start with row_count≠0 latches base/count, busy=1, goes to ISSUE. start with row_count=0 gives done pulse next cycle and stays IDLE, busy stays 0.
- ISSUE: pair index k drives rom_addr_1=base+2k and rom_addr_2=base+2k+1, both modulo 2^ADDR_WIDTH (wrap, no error).
  - Issue condition: in_flight + fifo_count < FIFO_DEPTH. On issue, a token enters the ROM_LATENCY-deep shift register, tagged with second_valid=(2k+1<row_count) and last=(final pair), and k advances.
  - When not issuing, addresses hold their value.
  - After the final pair is issued, go to DRAIN.
  - Pairs = ceil(row_count/2). On an odd count, the last pair has second_valid=0 and its port-2 data is discarded.
- Capture: a token exiting the shift register (aligned to rom_data_* valid) writes {rom_data_1, rom_data_2, tags} into the FIFO on that edge.
  - out_valid rises the cycle after the write; there is no bypass.
  - First out_valid is 4 edges after the start-sampling edge with defaults.
- Handshake: transfer when out_valid&&out_ready. out_* stable while out_valid&&!out_ready. Simultaneous push/pop is allowed; fifo_count is unchanged by it. FIFO can never overflow by construction of the credit check.
- DRAIN: when the out_last beat transfers (in_flight=0, FIFO empty), done pulses 1 cycle on the next edge, busy→0, return to IDLE. A start in that same cycle is ignored.

Optional Feature:
- Macro COEFF_FETCH_STALL_CNT_EN.
- Defined: adds output stall_cycles[15:0]. It counts cycles in ISSUE where issue is blocked by credit, saturates at 16'hFFFF, clears on accepted start, and resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- base=0, row_count=4, out_ready=1 → rom_addr pairs (0,1),(2,3) on consecutive cycles. Beats (5F5F5F5F,1A1A1A1A),(2E2E2E2E,A5A5A5A5); out_last on 2nd beat; done one cycle after it.
- base=4, row_count=3 → beats (123478A2,9C7B6A88,second_valid=1), then (AFAFB4C5,second_valid=0,out_last=1).
- base=15, row_count=2 → rom_addr_1=15, rom_addr_2=0 (wrap); single beat with out_last=1.
- FIFO_DEPTH=4, row_count=16, out_ready=0 → exactly 4 pairs issued then addresses freeze. With STALL_CNT_EN, stall_cycles increments each cycle. Raising out_ready → all 8 beats delivered in order, no loss or duplication.
- row_count=0 start → done pulse next cycle, busy stays 0, no out_valid.
- rst_n pulled low mid-burst (2 beats buffered) → out_valid=0, busy=0 immediately. A new start of base=0, count=2 → single beat (5F5F5F5F,1A1A1A1A) only.
